imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Serial boot loader sitting directly upstream of the stack CPU's instruction memory. It accepts a framed byte stream from the UART receiver, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses starting at 0. It verifies a frame checksum and holds the CPU in reset until a load completes cleanly. It drives the instruction-memory write port, which the CPU core itself never uses.

## Interface
- ABITS, 32, instruction-memory address width (word-indexed, matches CPU pc)
- MAX_WORDS, 1024, largest accepted word count; larger counts are rejected
- TIMEOUT, 100000, idle cycles allowed between bytes inside a frame
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- retry  in  1  single-cycle pulse; leaves ERROR and re-arms for a new frame
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ABITS  word address for the write
- imem_din  out  32  instruction word for the write
- cpu_reset  out  1  high while the CPU must be held in reset
- load_done  out  1  level; the frame loaded and the checksum matched
- load_error  out  1  level; the frame was aborted

## Operation
- Frame format: CNT_HI, CNT_LO (16-bit word count N, big-endian), then 4·N data bytes (each word MSB first), then 1 checksum byte.
- The checksum byte must equal the XOR of every preceding frame byte, count bytes included.
- A byte is accepted on a cycle with rx_valid && rx_ready. No other cycle affects state.
- States:
  - S_CNT_HI: waiting for the first count byte.
  - S_CNT_LO: waiting for the second count byte.
  - S_DATA: receiving data bytes.
  - S_CHECK: waiting for the checksum byte.
  - S_DONE: load complete.
  - S_ERROR: frame aborted.
- Transitions:
  - S_CNT_HI → S_CNT_LO on accept.
  - S_CNT_LO → S_ERROR on accept if N > MAX_WORDS.
  - S_CNT_LO → S_CHECK on accept if N == 0.
  - S_CNT_LO → S_DATA on accept otherwise.
  - S_DATA → S_CHECK after the 4·N-th data byte.
  - S_CHECK → S_DONE on accept if the byte matches the running XOR.
  - S_CHECK → S_ERROR on accept if it does not match.
  - S_ERROR → S_CNT_HI on retry. This clears the running XOR, byte index and word address to 0.
  - S_DONE is terminal until reset.
- rx_ready = 1 in S_CNT_HI, S_CNT_LO, S_DATA and S_CHECK; 0 in S_DONE and S_ERROR.
- Word assembly: shift register, new byte enters the LSB. On the 4th byte of a word:
  - imem_din and imem_addr are registered, and imem_we pulses on the next cycle.
  - The address then increments.
  - Address k holds word k, k = 0..N-1.
- Timeout counter:
  - Clears on every accepted byte.
  - Counts only in S_CNT_LO, S_DATA and S_CHECK.
  - Reaching TIMEOUT-1 → S_ERROR.
- Words already written before an error or a reset are not erased. The CPU stays in reset, so they are harmless.
- retry is ignored outside S_ERROR.

## Timing
- Reset values:
  - state S_CNT_HI
  - rx_ready 1
  - imem_we 0
  - imem_addr 0
  - imem_din 0
  - cpu_reset 1
  - load_done 0
  - load_error 0
- Write latency: imem_we is high exactly one cycle, the cycle after the 4th byte of the word is accepted.
- Back-to-back bytes at one byte per cycle are supported; no bubbles are required.
- Done: load_done rises and cpu_reset falls in the cycle after the matching checksum byte is accepted. The final imem_we has already completed by then.
- Error: load_error rises the cycle after the faulting byte or the timeout.
  - cpu_reset stays 1.
  - load_error clears the cycle after retry is sampled.
- Reset mid-frame: asynchronous return to the reset values.
  - imem_we drops immediately.
  - A partially assembled word is discarded.

## Test plan
- Two-word load. Frame 00 02 04 00 00 01 DE AD BE EF 25 sent back-to-back. Required:
  - imem_we pulses at addr 0 with 0x04000001, then at addr 1 with 0xDEADBEEF.
  - load_done = 1 and cpu_reset = 0 one cycle after the 0x25 byte.
  - rx_ready = 0 afterwards.
- Empty load. Frame 00 00 00. Required: no imem_we; load_done = 1.
- Bad checksum. Two-word frame with last byte 0x26. Required:
  - Both writes occur, load_error = 1 and cpu_reset stays 1.
  - After retry, the valid frame loads and load_done = 1.
- Oversize count. Bytes 04 01 (N = 1025) with MAX_WORDS = 1024. Required: load_error = 1 after CNT_LO; no writes; rx_ready = 0.
- Timeout. Bench runs with TIMEOUT = 16; send 00 02 04, then idle. Required: load_error = 1 after 16 idle cycles; no imem_we.
- Gaps and reset. Random rx_valid gaps (no timeout) give writes identical to the back-to-back case. Asserting reset after 6 bytes gives:
  - immediate return to reset values;
  - a fresh full frame then loads from addr 0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: turns a framed UART byte stream into big-endian 32-bit words written
// from instruction-memory address 0. It checks an XOR checksum and holds the CPU in reset until a clean load.
// Latency: imem_we one cycle after a word's 4th byte; status one cycle after the checksum or fault. rx_ready drops in DONE/ERROR.
module imem_boot_loader #(
   parameter int ABITS     = 32,
   parameter int MAX_WORDS = 1024,
   parameter int TIMEOUT   = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   input  logic             retry,
   output logic             imem_we,
   output logic [ABITS-1:0] imem_addr,
   output logic [31:0]      imem_din,
   output logic             cpu_reset,
   output logic             load_done,
   output logic             load_error
);

   typedef enum logic [2:0] {
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t           state;
   logic [7:0]       cnt_hi;      // first count byte, held until the low byte arrives
   logic [7:0]       xor_acc;     // running XOR of every accepted frame byte
   logic [15:0]      words_left;  // words still to be written in S_DATA
   logic [1:0]       byte_pos;    // byte position within the word being assembled
   logic [23:0]      shift;       // first three bytes of the current word
   logic [ABITS-1:0] addr;        // next word address to write
   logic [31:0]      timer;       // idle cycles since the last accepted byte

   logic        accept;
   logic [31:0] count_full;
   logic        timer_on;
   logic        timeout_hit;
   logic        fault;

   assign accept      = rx_valid && rx_ready;
   // Word count as it will be once the current byte is taken as CNT_LO.
   assign count_full  = {16'd0, cnt_hi, rx_data};
   assign timer_on    = (state == S_CNT_LO) || (state == S_DATA) || (state == S_CHECK);
   assign timeout_hit = timer_on && !accept && (timer == 32'(TIMEOUT - 1));

   // Every condition that aborts the frame; it overrides the normal transition below.
   always_comb begin
      fault = timeout_hit;
      if (accept && (state == S_CNT_LO) && (count_full > 32'(MAX_WORDS)))
         fault = 1'b1;
      if (accept && (state == S_CHECK) && (rx_data != xor_acc))
         fault = 1'b1;
   end

   // Frame FSM with word assembly, write port, idle timer and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_CNT_HI;
         cnt_hi     <= 8'd0;
         xor_acc    <= 8'd0;
         words_left <= 16'd0;
         byte_pos   <= 2'd0;
         shift      <= 24'd0;
         addr       <= '0;
         timer      <= 32'd0;
         rx_ready   <= 1'b1;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_din   <= 32'd0;
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         imem_we <= 1'b0;

         if (accept)
            timer <= 32'd0;
         else if (timer_on)
            timer <= timer + 32'd1;

         if (accept)
            xor_acc <= xor_acc ^ rx_data;

         case (state)
            S_CNT_HI: begin
               if (accept) begin
                  cnt_hi <= rx_data;
                  state  <= S_CNT_LO;
               end
            end
            S_CNT_LO: begin
               if (accept) begin
                  words_left <= count_full[15:0];
                  if (count_full == 32'd0)
                     state <= S_CHECK;
                  else
                     state <= S_DATA;
               end
            end
            S_DATA: begin
               if (accept) begin
                  shift    <= {shift[15:0], rx_data};
                  byte_pos <= byte_pos + 2'd1;
                  if (byte_pos == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_din   <= {shift, rx_data};
                     imem_addr  <= addr;
                     addr       <= addr + ABITS'(1);
                     words_left <= words_left - 16'd1;
                     if (words_left == 16'd1)
                        state <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               if (accept && (rx_data == xor_acc)) begin
                  state     <= S_DONE;
                  rx_ready  <= 1'b0;
                  cpu_reset <= 1'b0;
                  load_done <= 1'b1;
               end
            end
            S_DONE: begin
               // Terminal until reset.
            end
            S_ERROR: begin
               if (retry) begin
                  state      <= S_CNT_HI;
                  rx_ready   <= 1'b1;
                  load_error <= 1'b0;
                  xor_acc    <= 8'd0;
                  byte_pos   <= 2'd0;
                  shift      <= 24'd0;
                  addr       <= '0;
                  timer      <= 32'd0;
               end
            end
            default: begin
               state    <= S_CNT_HI;
               rx_ready <= 1'b1;
            end
         endcase

         if (fault) begin
            state      <= S_ERROR;
            rx_ready   <= 1'b0;
            load_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed frames plus randomized frames and gaps,
// compared every cycle against a frame-level model (accepted-byte queue + rules).
module tb_imem_boot_loader;

   localparam int TMO  = 16;
   localparam int MAXW = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        retry;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_din;
   logic        cpu_reset;
   logic        load_done;
   logic        load_error;

   imem_boot_loader #(
      .ABITS(32),
      .MAX_WORDS(MAXW),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .retry(retry),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .imem_din(imem_din),
      .cpu_reset(cpu_reset),
      .load_done(load_done),
      .load_error(load_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model: frame as a queue of accepted bytes ----------------
   logic [7:0]  frame[$];
   bit          m_done, m_err;
   int          idle;
   logic        m_we;
   logic [31:0] m_addr, m_din;
   logic [63:0] exp_log[$];

   function automatic bit m_ready();
      return !(m_done || m_err);
   endfunction

   task automatic model_reset();
      frame.delete();
      m_done = 0; m_err = 0; idle = 0;
      m_we = 0; m_addr = 0; m_din = 0;
   endtask

   // One clock edge as the spec describes it, given the inputs sampled at that edge.
   task automatic model_cycle(input logic v, input logic [7:0] d, input logic r);
      int n, nw, k;
      logic [7:0] x;
      m_we = 0;
      if (v && m_ready()) begin
         frame.push_back(d);
         idle = 0;
         n = frame.size();
         if (n >= 2) begin
            nw = int'({frame[0], frame[1]});
            if (n == 2) begin
               if (nw > MAXW) m_err = 1;
            end else begin
               k = n - 2;
               if (k <= 4 * nw) begin
                  if (k % 4 == 0) begin
                     m_we   = 1;
                     m_addr = 32'(k / 4 - 1);
                     m_din  = {frame[n-4], frame[n-3], frame[n-2], frame[n-1]};
                     exp_log.push_back({m_addr, m_din});
                  end
               end else begin
                  x = 8'h00;
                  for (int i = 0; i < n - 1; i++) x = x ^ frame[i];
                  if (d == x) m_done = 1; else m_err = 1;
               end
            end
         end
      end else if (m_err) begin
         if (r) begin
            m_err = 0;
            frame.delete();
            idle = 0;
         end
      end else if (!m_done && frame.size() > 0) begin
         idle++;
         if (idle >= TMO) m_err = 1;
      end
   endtask

   // ---------------- compare process + write collector ----------------
   logic [63:0] dut_wr[$];
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("rx_ready",   64'(rx_ready),   64'(m_ready()));
         chk("imem_we",    64'(imem_we),    64'(m_we));
         chk("imem_addr",  64'(imem_addr),  64'(m_addr));
         chk("imem_din",   64'(imem_din),   64'(m_din));
         chk("cpu_reset",  64'(cpu_reset),  64'(!m_done));
         chk("load_done",  64'(load_done),  64'(m_done));
         chk("load_error", 64'(load_error), 64'(m_err));
      end
      if (!reset && imem_we) dut_wr.push_back({imem_addr, imem_din});
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] txq[$];

   task automatic step(input logic v, input logic [7:0] d, input logic r);
      rx_valid = v; rx_data = d; retry = r;
      @(posedge clk);
      model_cycle(v, d, r);
      #1;
      rx_valid = 1'b0; retry = 1'b0;
   endtask

   task automatic send_frame(input int max_gap);
      foreach (txq[i]) begin
         repeat ($urandom_range(0, max_gap)) step(1'b0, 8'h00, 1'b0);
         step(1'b1, txq[i], 1'b0);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; rx_valid = 1'b0; retry = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic make_frame(input int nw, input bit bad);
      logic [7:0]  x;
      logic [31:0] w;
      logic [15:0] n16;
      txq.delete();
      n16 = 16'(nw);
      txq.push_back(n16[15:8]);
      txq.push_back(n16[7:0]);
      for (int i = 0; i < nw; i++) begin
         w = $urandom;
         txq.push_back(w[31:24]); txq.push_back(w[23:16]);
         txq.push_back(w[15:8]);  txq.push_back(w[7:0]);
      end
      x = 8'h00;
      foreach (txq[i]) x = x ^ txq[i];
      txq.push_back(bad ? ~x : x);
   endtask

   task automatic check_two_word_writes(input string tag);
      chk({tag, "_nwr"}, 64'(dut_wr.size()), 64'd2);
      if (dut_wr.size() == 2) begin
         chk({tag, "_wr0"}, dut_wr[0], {32'd0, 32'h04000001});
         chk({tag, "_wr1"}, dut_wr[1], {32'd1, 32'hDEADBEEF});
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; retry = 1'b0;
      model_reset();
      cmp_en = 1'b1;
      @(posedge clk); #1;
      // Reset values held while reset is asserted.
      chk("rst_rx_ready", 64'(rx_ready), 64'd1);
      chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
      chk("rst_imem_we", 64'(imem_we), 64'd0);
      chk("rst_load_done", 64'(load_done), 64'd0);
      do_reset();

      // Two-word load, back-to-back.
      dut_wr.delete(); exp_log.delete();
      txq = '{8'h00, 8'h02, 8'h04, 8'h00, 8'h00, 8'h01,
              8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h25};
      send_frame(0);
      chk("t1_load_done", 64'(load_done), 64'd1);
      chk("t1_cpu_reset", 64'(cpu_reset), 64'd0);
      chk("t1_rx_ready", 64'(rx_ready), 64'd0);
      check_two_word_writes("t1");
      chk("model_log_n", 64'(exp_log.size()), 64'd2);
      if (exp_log.size() == 2)
         chk("model_log1", exp_log[1], {32'd1, 32'hDEADBEEF});
      step(1'b0, 8'h00, 1'b0);
      chk("t1_done_hold", 64'(load_done), 64'd1);
      do_reset();

      // Empty load.
      dut_wr.delete();
      txq = '{8'h00, 8'h00, 8'h00};
      send_frame(0);
      chk("t2_load_done", 64'(load_done), 64'd1);
      chk("t2_nwr", 64'(dut_wr.size()), 64'd0);
      do_reset();

      // Bad checksum, then retry and a good frame.
      dut_wr.delete();
      txq = '{8'h00, 8'h02, 8'h04, 8'h00, 8'h00, 8'h01,
              8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26};
      send_frame(0);
      chk("t3_load_error", 64'(load_error), 64'd1);
      chk("t3_cpu_reset", 64'(cpu_reset), 64'd1);
      check_two_word_writes("t3");
      step(1'b0, 8'h00, 1'b1);
      chk("t3_err_clear", 64'(load_error), 64'd0);
      dut_wr.delete();
      txq[10] = 8'h25;
      send_frame(0);
      chk("t3_retry_done", 64'(load_done), 64'd1);
      check_two_word_writes("t3r");
      do_reset();

      // Oversize count; bytes offered during ERROR are ignored; retry re-arms.
      dut_wr.delete();
      txq = '{8'h04, 8'h01};
      send_frame(0);
      chk("t4_load_error", 64'(load_error), 64'd1);
      chk("t4_rx_ready", 64'(rx_ready), 64'd0);
      step(1'b1, 8'h55, 1'b0);
      chk("t4_nwr", 64'(dut_wr.size()), 64'd0);
      step(1'b0, 8'h00, 1'b1);
      chk("t4_rearm", 64'(rx_ready), 64'd1);
      do_reset();

      // Exactly MAX_WORDS is accepted.
      txq = '{8'h04, 8'h00};
      send_frame(0);
      step(1'b0, 8'h00, 1'b0);
      chk("t4b_no_error", 64'(load_error), 64'd0);
      do_reset();

      // Timeout after 16 idle cycles inside a frame.
      dut_wr.delete();
      txq = '{8'h00, 8'h02, 8'h04};
      send_frame(0);
      repeat (TMO - 1) step(1'b0, 8'h00, 1'b0);
      chk("t5_not_yet", 64'(load_error), 64'd0);
      step(1'b0, 8'h00, 1'b0);
      chk("t5_timeout", 64'(load_error), 64'd1);
      chk("t5_nwr", 64'(dut_wr.size()), 64'd0);
      step(1'b0, 8'h00, 1'b1);
      do_reset();

      // Random gaps give the same writes.
      dut_wr.delete();
      txq = '{8'h00, 8'h02, 8'h04, 8'h00, 8'h00, 8'h01,
              8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h25};
      send_frame(5);
      chk("t6_load_done", 64'(load_done), 64'd1);
      check_two_word_writes("t6");
      do_reset();

      // Asynchronous reset after 6 bytes (the word-0 write strobe is high).
      for (int i = 0; i < 6; i++) step(1'b1, txq[i], 1'b0);
      chk("t7_we_before", 64'(imem_we), 64'd1);
      reset = 1'b1;
      #1;
      chk("t7_we_async", 64'(imem_we), 64'd0);
      chk("t7_addr_async", 64'(imem_addr), 64'd0);
      chk("t7_ready_async", 64'(rx_ready), 64'd1);
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      dut_wr.delete();
      send_frame(2);
      chk("t7_load_done", 64'(load_done), 64'd1);
      check_two_word_writes("t7");
      do_reset();

      // Randomized frames; the compare process checks every cycle.
      for (int f = 0; f < 10; f++) begin
         make_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
         send_frame($urandom_range(0, 3));
         step(1'b0, 8'h00, 1'b0);
         chk("rnd_finished", 64'(load_done || load_error), 64'd1);
         do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
